dmux4_load_scheduler: RTL and testbench
=======================================

Name: dmux4_load_scheduler

Overview:
- Sequences writes onto a 4-way load demultiplexer that fans one load strobe to four memory banks or registers.
- Buffers incoming write requests (data plus 2-bit destination) in a small in-order FIFO.
- Issues each request as a one-cycle load pulse with a matching select and data once the target bank is ready and past its recovery window.
- Sits between the CPU/bus write path and the demux/bank array.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- RECOVERY, 1, minimum idle cycles after a load before the same bank may be loaded again; 0 allows back-to-back loads to one bank.
- WIDTH, 16, data word width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  write request present.
- in_ready  output  1  scheduler can accept a request.
- in_data  input  WIDTH  write data.
- in_dest  input  2  destination bank 0..3.
- bank_ready  input  4  per-bank ready; bit b high means bank b can take a load this cycle.
- load  output  1  registered load strobe to the demux input.
- sel  output  2  registered demux select.
- data_out  output  WIDTH  registered data to the banks.
- busy  output  1  FIFO non-empty or load high.
- issue_count  output  16  number of loads issued, wrapping.

Behaviour:
- Reset (rst_n low, takes effect immediately without waiting for clk):
  - FIFO emptied; all recovery counters cleared.
  - load=0, sel=0, data_out=0, issue_count=0, busy=0.
  - in_ready=1 once reset has been released.
  - Reset during an active pulse drops load at once; queued requests are discarded.
- Accept:
  - in_ready = !full. It is combinational from FIFO state only and does not depend on a same-cycle pop.
  - Push on a clock edge when in_valid && in_ready.
  - in_valid while full is ignored and the data is not captured. The upstream block must hold the request until it is accepted.
- Issue condition (evaluated each cycle on the FIFO head, strictly in order):
  - FIFO not empty,
  - bank_ready[head_dest]=1, and
  - rec_cnt[head_dest]=0.
- When the condition holds, at the next edge:
  - head is popped;
  - load<=1, sel<=head_dest, data_out<=head_data;
  - rec_cnt[head_dest]<=RECOVERY;
  - issue_count<=issue_count+1 (0xFFFF wraps to 0x0000).
- Otherwise:
  - load<=0;
  - sel and data_out hold their last values.
- Head-of-line blocking: a blocked head stalls all later entries, even those to ready banks. No reordering.
- Recovery counters:
  - Each rec_cnt[b] decrements by 1 per cycle while non-zero.
  - On the edge that issues to bank b, the reload to RECOVERY wins over the decrement.
- Timing:
  - Minimum latency: request accepted at edge t into an empty FIFO with the bank ready → load high in the cycle after edge t+1.
  - Maximum throughput: one load per cycle when consecutive heads target different ready banks, or the same bank with RECOVERY=0.
  - Simultaneous push and pop in the same cycle is allowed when not full; the count is unchanged.
- Effective states (derived, not necessarily encoded):
  - EMPTY: FIFO empty.
  - BLOCKED: head present, condition false.
  - ISSUE: condition true.
  - EMPTY→BLOCKED/ISSUE on push. ISSUE→EMPTY when the last entry pops. BLOCKED→ISSUE when the bank becomes ready or its recovery expires.
- busy = (FIFO count ≠ 0) | load.

Test Plan:
- Reset release, single request (in_data=0x1234, in_dest=2, bank_ready=4'b1111) → load high exactly one cycle, 2 cycles after accept; sel=2, data_out=0x1234; issue_count=1; busy falls the cycle after load.
- Back-to-back pushes to dests 0,1,2,3 with all banks ready, RECOVERY=1 → four consecutive load cycles with sel=0,1,2,3; issue_count=4.
- Two pushes to dest 1, RECOVERY=2 → loads separated by exactly 2 idle cycles; sel=1 both times.
- bank_ready[3]=0, push dest 3 then dest 0 → no load while blocked, dest 0 not issued. Raise bank_ready[3] → sel=3 load, then sel=0 load next cycle.
- Bank held not ready, push 5 requests with DEPTH=4 → in_ready=0 after 4 accepts, fifth held by upstream. Release bank → all 5 issue in order, in_ready returns high after first pop.
- Assert rst_n=0 mid-pulse with 3 entries queued → load=0 immediately, busy=0, issue_count=0. No loads after release until new pushes.

Source files
------------

// File: rtl/dmux4_load_scheduler.sv
// In-order write scheduler for a 4-way load demux: queues (data, dest) requests
// and issues each as a one-cycle load pulse once its bank is ready and recovered.
module dmux4_load_scheduler #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned RECOVERY = 1,
  parameter int unsigned WIDTH    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_dest,
  input  logic [3:0]       bank_ready,
  output logic             load,
  output logic [1:0]       sel,
  output logic [WIDTH-1:0] data_out,
  output logic             busy,
  output logic [15:0]      issue_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned RW = (RECOVERY < 1) ? 1 : $clog2(RECOVERY + 1);

  logic [WIDTH-1:0] r_mem_data [DEPTH];
  logic [1:0]       r_mem_dest [DEPTH];
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_count;
  logic [RW-1:0]    r_rec_cnt [4];
  logic             r_load;
  logic [1:0]       r_sel;
  logic [WIDTH-1:0] r_data_out;
  logic [15:0]      r_issue_count;

  logic             w_push;
  logic             w_issue;
  logic [1:0]       w_head_dest;
  logic [WIDTH-1:0] w_head_data;
  logic [CW-1:0]    w_count_nxt;

  // Full flag comes from registered occupancy only, never from a same-cycle pop.
  assign in_ready    = (r_count != CW'(DEPTH));
  assign w_push      = in_valid && in_ready;
  assign w_head_dest = r_mem_dest[r_rd_ptr];
  assign w_head_data = r_mem_data[r_rd_ptr];
  assign w_issue     = (r_count != CW'(0)) && bank_ready[w_head_dest] &&
                       (r_rec_cnt[w_head_dest] == RW'(0));

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_issue) begin
      w_count_nxt = r_count + CW'(1);
    end else if (!w_push && w_issue) begin
      w_count_nxt = r_count - CW'(1);
    end
  end

  // Payload storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr] <= in_data;
      r_mem_dest[r_wr_ptr] <= in_dest;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_count <= w_count_nxt;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_issue) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
    end
  end

  // Per-bank recovery: reload on issue takes priority over the countdown.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 4; b++) begin
        r_rec_cnt[b] <= '0;
      end
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (w_issue && (w_head_dest == 2'(b))) begin
          r_rec_cnt[b] <= RW'(RECOVERY);
        end else if (r_rec_cnt[b] != RW'(0)) begin
          r_rec_cnt[b] <= r_rec_cnt[b] - RW'(1);
        end
      end
    end
  end

  // Load pulse; select and data hold their last issued values between pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_load        <= 1'b0;
      r_sel         <= '0;
      r_data_out    <= '0;
      r_issue_count <= '0;
    end else begin
      r_load <= w_issue;
      if (w_issue) begin
        r_sel         <= w_head_dest;
        r_data_out    <= w_head_data;
        r_issue_count <= r_issue_count + 16'(1);
      end
    end
  end

  assign load        = r_load;
  assign sel         = r_sel;
  assign data_out    = r_data_out;
  assign issue_count = r_issue_count;
  assign busy        = (r_count != CW'(0)) || r_load;

endmodule

// File: tb/tb_dmux4_load_scheduler.sv
// Bench for dmux4_load_scheduler: directed scenarios plus random traffic,
// compared every cycle against a queue/timestamp reference model.
module tb_dmux4_load_scheduler;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned REC   = 2;
  localparam int unsigned WIDTH = 16;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [1:0]       dest;
  } req_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_dest;
  logic [3:0]       bank_ready;
  logic             load;
  logic [1:0]       sel;
  logic [WIDTH-1:0] data_out;
  logic             busy;
  logic [15:0]      issue_count;

  dmux4_load_scheduler #(.DEPTH(DEPTH), .RECOVERY(REC), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_dest(in_dest), .bank_ready(bank_ready),
    .load(load), .sel(sel), .data_out(data_out), .busy(busy),
    .issue_count(issue_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: upstream backlog, FIFO contents, last-issue edge per bank.
  req_t             pending[$];
  req_t             mq[$];
  int               last_edge [4];
  int               edge_no;
  logic             m_load;
  logic [1:0]       m_sel;
  logic [WIDTH-1:0] m_data;
  logic [15:0]      m_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    pending.delete();
    mq.delete();
    for (int b = 0; b < 4; b++) last_edge[b] = -1000;
    edge_no = 0;
    m_load  = 1'b0;
    m_sel   = 2'd0;
    m_data  = '0;
    m_cnt   = 16'd0;
  endtask

  // One clock edge of the specified behaviour, using pre-edge state.
  task automatic model_edge();
    bit   issue;
    bit   accept;
    req_t h;
    accept = in_valid && (mq.size() < DEPTH);
    issue  = 1'b0;
    if (mq.size() > 0) begin
      h     = mq[0];
      issue = bank_ready[h.dest] && ((edge_no - last_edge[h.dest]) > int'(REC));
    end
    if (issue) begin
      m_load = 1'b1;
      m_sel  = h.dest;
      m_data = h.data;
      m_cnt  = m_cnt + 16'd1;
      last_edge[h.dest] = edge_no;
      void'(mq.pop_front());
    end else begin
      m_load = 1'b0;
    end
    if (accept) begin
      mq.push_back(pending.pop_front());
    end
    edge_no++;
  endtask

  task automatic check_all(input string ph);
    check({ph, ".load"},        32'(load),        32'(m_load));
    check({ph, ".sel"},         32'(sel),         32'(m_sel));
    check({ph, ".data_out"},    32'(data_out),    32'(m_data));
    check({ph, ".issue_count"}, 32'(issue_count), 32'(m_cnt));
    check({ph, ".busy"},        32'(busy),        32'((mq.size() != 0) || m_load));
    check({ph, ".in_ready"},    32'(in_ready),    32'(mq.size() < DEPTH));
  endtask

  // Called at a negedge: drive the backlog head, take one edge, check at next negedge.
  task automatic run_cycles(input int n, input string ph);
    for (int i = 0; i < n; i++) begin
      in_valid = (pending.size() > 0);
      if (pending.size() > 0) begin
        in_data = pending[0].data;
        in_dest = pending[0].dest;
      end else begin
        in_data = WIDTH'($urandom);
        in_dest = 2'($urandom);
      end
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_all(ph);
    end
  endtask

  task automatic add_req(input logic [WIDTH-1:0] d, input logic [1:0] dst);
    req_t r;
    r.data = d;
    r.dest = dst;
    pending.push_back(r);
  endtask

  initial begin
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    in_dest    = 2'd0;
    bank_ready = 4'hF;
    model_reset();
    #2;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;
    run_cycles(2, "idle");

    // Single request, minimum latency.
    add_req(16'h1234, 2'd2);
    run_cycles(6, "single");

    // One push per bank: back-to-back loads.
    for (int b = 0; b < 4; b++) add_req(16'hA000 + 16'(b), 2'(b));
    run_cycles(10, "fanout");

    // Same bank twice: recovery gap.
    add_req(16'h0B01, 2'd1);
    add_req(16'h0B02, 2'd1);
    run_cycles(10, "recovery");

    // Head-of-line blocking on bank 3.
    bank_ready = 4'b0111;
    add_req(16'h3333, 2'd3);
    add_req(16'h0000, 2'd0);
    run_cycles(6, "hol_blocked");
    bank_ready = 4'hF;
    run_cycles(6, "hol_release");

    // Fill to DEPTH with a fifth request held upstream.
    bank_ready = 4'b0000;
    for (int i = 0; i < 5; i++) add_req(16'h5000 + 16'(i), 2'(i));
    run_cycles(8, "full");
    bank_ready = 4'hF;
    run_cycles(16, "drain");

    // Reset mid-pulse with entries still queued.
    bank_ready = 4'b0000;
    for (int i = 0; i < 4; i++) add_req(16'h7000 + 16'(i), 2'd0);
    run_cycles(5, "preload");
    bank_ready = 4'hF;
    run_cycles(1, "pulse");
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    run_cycles(5, "post_reset");

    // Random traffic and bank readiness.
    for (int c = 0; c < 400; c++) begin
      bank_ready = 4'($urandom);
      if (($urandom_range(0, 2) != 0) && (pending.size() < 3)) begin
        add_req(WIDTH'($urandom), 2'($urandom));
      end
      run_cycles(1, "random");
    end
    bank_ready = 4'hF;
    run_cycles(30, "final_drain");
    check("final_empty", 32'(busy), 32'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
